// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
//   Round-robin arbiter/sequencer sharing one integer square-root unit among
//   N_REQ requesters. A granted operand is sent to the unit with a single
//   start pulse, the result is captured on unit_valid and returned with a
//   one-cycle one-hot done strobe.
//
//   Ports:
//     clk         in   system clock, rising edge
//     reset       in   asynchronous active-low reset
//     req         in   [N_REQ]        per-requester request level
//     req_a       in   [N_REQ*WIDTH]  packed operands, requester i at [i*WIDTH +: WIDTH]
//     done        out  [N_REQ]        one-hot completion strobe
//     result      out  [WIDTH]        result for the requester flagged by done
//     err         out                 timeout flag, qualified by done
//     busy        out                 high whenever not IDLE
//     unit_start  out                 start pulse to the square-root unit
//     unit_a      out  [WIDTH]        operand to the square-root unit
//     unit_valid  in                  square-root unit result valid
//     unit_sqrt   in   [WIDTH]        square-root unit result
//
//   Optional feature macro: SQRT_ARB_TIMEOUT_EN
//     When defined, WAIT gives up after TIMEOUT_CYCLES cycles and delivers
//     result = all ones with err = 1. When undefined, err is tied low.

module sqrt_arbiter #(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    output logic [N_REQ-1:0]         done,
    output logic [WIDTH-1:0]         result,
    output logic                     err,
    output logic                     busy,
    output logic                     unit_start,
    output logic [WIDTH-1:0]         unit_a,
    input  logic                     unit_valid,
    input  logic [WIDTH-1:0]         unit_sqrt
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic             unit_start_q, unit_start_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] opnd [N_REQ];
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_opnd
        assign opnd[g] = req_a[g*WIDTH +: WIDTH];
    end

    always_comb begin
        // Rotating scan: first set req bit at or above the pointer, wrapping.
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((k + 32'(ptr_q)) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        unit_a_d = unit_a_q;
        result_d = result_q;
        done_d   = '0;
        err_d    = 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    unit_a_d = opnd[pick];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SQRT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // A valid sampled in ISSUE never reaches here, so it is ignored.
                if (unit_valid) begin
                    result_d        = unit_sqrt;
                    done_d[grant_q] = 1'b1;
                    state_d         = S_DELIVER;
                end
`ifdef SQRT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d        = '1;
                    err_d           = 1'b1;
                    done_d[grant_q] = 1'b1;
                    state_d         = S_DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                // DELIVER: served requester becomes lowest priority.
                ptr_d   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        unit_start_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            unit_a_q     <= '0;
            unit_start_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            result_q     <= result_d;
            unit_a_q     <= unit_a_d;
            unit_start_q <= unit_start_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef SQRT_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign done       = done_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign unit_start = unit_start_q;
    assign unit_a     = unit_a_q;
`ifdef SQRT_ARB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
    logic unused_err_q;
    assign unused_err_q = err_q;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter
//   Directed bench for sqrt_arbiter (N_REQ=4, WIDTH=8). The bench plays the
//   square-root unit itself, returning hand-computed roots. Inputs change and
//   outputs are sampled on the falling clock edge.

module tb_sqrt_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           err;
    logic           busy;
    logic           unit_start;
    logic [W-1:0]   unit_a;
    logic           unit_valid;
    logic [W-1:0]   unit_sqrt;

    int n_asserts = 0;
    int n_fail    = 0;

    sqrt_arbiter #(
        .N_REQ         (N),
        .WIDTH         (W),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .unit_start (unit_start),
        .unit_a     (unit_a),
        .unit_valid (unit_valid),
        .unit_sqrt  (unit_sqrt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] v);
        req_a[i*W +: W] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},   32'(done),       0);
        chk({tag, "_result"}, 32'(result),     0);
        chk({tag, "_err"},    32'(err),        0);
        chk({tag, "_busy"},   32'(busy),       0);
        chk({tag, "_start"},  32'(unit_start), 0);
        chk({tag, "_unit_a"}, 32'(unit_a),     0);
    endtask

    // Called on a falling edge. Waits (bounded) for the start pulse, checks
    // the operand, holds the unit busy for extra_wait WAIT cycles, returns sq
    // and checks the delivery. Returns on the falling edge of the done cycle,
    // having dropped the served request.
    task automatic service(input int exp_idx, input logic [W-1:0] exp_a,
                           input logic [W-1:0] sq, input int extra_wait, input int budget);
        int n;
        logic [N-1:0] exp_done;
        n = 0;
        while (!unit_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen",  32'(unit_start), 1);
        chk("unit_a",      32'(unit_a),     32'(exp_a));
        chk("busy_issue",  32'(busy),       1);
        chk("done_issue",  32'(done),       0);
        @(negedge clk);
        chk("start_one_cycle", 32'(unit_start), 0);
        repeat (extra_wait) begin
            @(negedge clk);
            chk("done_while_wait", 32'(done), 0);
        end
        unit_valid = 1'b1;
        unit_sqrt  = sq;
        @(negedge clk);
        unit_valid = 1'b0;
        unit_sqrt  = '0;
        exp_done = '0;
        exp_done[exp_idx] = 1'b1;
        chk("done_onehot", 32'(done),   32'(exp_done));
        chk("result",      32'(result), 32'(sq));
        chk("err_normal",  32'(err),    0);
        req[exp_idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b0;
        req        = '0;
        req_a      = '0;
        unit_valid = 1'b0;
        unit_sqrt  = '0;

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        // Single request: sqrt(49) = 7
        set_op(0, 8'd49);
        req = 4'b0001;
        service(0, 8'd49, 8'd7, 2, 4);
        @(negedge clk);
        chk("single_done_clear", 32'(done),   0);
        chk("single_busy_idle",  32'(busy),   0);
        chk("single_result_hold", 32'(result), 7);
        chk("single_unit_a_hold", 32'(unit_a), 49);

        // Contention from reset: order 0,1,2,3, one IDLE cycle between services
        reset = 1'b0;
        set_op(0, 8'd0);
        set_op(1, 8'd1);
        set_op(2, 8'd200);
        set_op(3, 8'd255);
        req = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        service(0, 8'd0, 8'd0, 0, 4);
        @(negedge clk);
        chk("cont_idle0", 32'(busy), 0);
        service(1, 8'd1, 8'd1, 1, 1);
        @(negedge clk);
        chk("cont_idle1", 32'(busy), 0);
        service(2, 8'd200, 8'd14, 3, 1);
        @(negedge clk);
        chk("cont_idle2", 32'(busy), 0);
        service(3, 8'd255, 8'd15, 0, 1);
        @(negedge clk);
        chk("cont_done_clear", 32'(done), 0);

        // Fairness: pointer is 0; serve 0, re-assert 0 while 2 pends -> 2 first
        set_op(0, 8'd16);
        set_op(2, 8'd100);
        req = 4'b0101;
        service(0, 8'd16, 8'd4, 1, 4);
        @(negedge clk);
        req[0] = 1'b1;
        service(2, 8'd100, 8'd10, 0, 4);
        @(negedge clk);
        service(0, 8'd16, 8'd4, 2, 4);
        @(negedge clk);

        // Reset in WAIT: outputs clear asynchronously, no done afterwards
        set_op(1, 8'd81);
        req = 4'b0010;
        n = 0;
        while (!unit_start && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("rst_start_seen", 32'(unit_start), 1);
        @(negedge clk);
        chk("rst_in_wait_busy", 32'(busy), 1);
        reset = 1'b0;
        req   = '0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(done), 0);
            chk("idle_after_reset_mid", 32'(busy), 0);
        end
        req = 4'b0010;
        service(1, 8'd81, 8'd9, 0, 4);
        @(negedge clk);

        // Zero-wait unit: done visible after the third rising edge
        set_op(2, 8'd9);
        req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        chk("zw_start", 32'(unit_start), 1);
        chk("zw_unit_a", 32'(unit_a), 9);
        @(posedge clk);
        @(negedge clk);
        chk("zw_no_done_yet", 32'(done), 0);
        unit_valid = 1'b1;
        unit_sqrt  = 8'd3;
        @(posedge clk);
        #1;
        chk("zw_done", 32'(done), 32'(4'b0100));
        chk("zw_result", 32'(result), 3);
        @(negedge clk);
        unit_valid = 1'b0;
        unit_sqrt  = '0;
        req[2] = 1'b0;
        @(negedge clk);

        // Valid pulse during ISSUE only: ignored, no done
        set_op(3, 8'd144);
        req = 4'b1000;
        @(negedge clk);
        chk("issue_pulse_start", 32'(unit_start), 1);
        unit_valid = 1'b1;
        unit_sqrt  = 8'd99;
        @(negedge clk);
        unit_valid = 1'b0;
        unit_sqrt  = '0;
        chk("issue_pulse_no_done0", 32'(done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("issue_pulse_no_done", 32'(done), 0);
            chk("issue_pulse_busy", 32'(busy), 1);
        end
        unit_valid = 1'b1;
        unit_sqrt  = 8'd12;
        @(negedge clk);
        unit_valid = 1'b0;
        unit_sqrt  = '0;
        chk("issue_pulse_real_done", 32'(done), 32'(4'b1000));
        chk("issue_pulse_result", 32'(result), 12);
        req[3] = 1'b0;
        @(negedge clk);

`ifdef SQRT_ARB_TIMEOUT_EN
        // Timeout: no valid -> done after 64 WAIT cycles, result FF, err 1
        set_op(0, 8'd200);
        req = 4'b0001;
        n = 0;
        while (!unit_start && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("to_start", 32'(unit_start), 1);
        n = 0;
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_wait_len", 32'(n), 65);
        chk("to_done", 32'(done), 32'(4'b0001));
        chk("to_result", 32'(result), 32'hFF);
        chk("to_err", 32'(err), 1);
        req = '0;
        @(negedge clk);
        chk("to_err_clear", 32'(err), 0);

        // Valid on WAIT cycle 64 wins over the timeout
        set_op(1, 8'd200);
        req = 4'b0010;
        n = 0;
        while (!unit_start && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("tv_start", 32'(unit_start), 1);
        repeat (64) @(negedge clk);
        chk("tv_no_done_yet", 32'(done), 0);
        unit_valid = 1'b1;
        unit_sqrt  = 8'd14;
        @(negedge clk);
        unit_valid = 1'b0;
        unit_sqrt  = '0;
        chk("tv_done", 32'(done), 32'(4'b0010));
        chk("tv_result", 32'(result), 14);
        chk("tv_err", 32'(err), 0);
        req = '0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
